// File: rtl/xor_decrypt.sv
// xor_decrypt: byte-serial XOR decryptor (receive-side counterpart of the
// XOR encryptor). Waits for both shift-in counters to report full, snapshots
// ciphertext and key, then recovers one KEY_WIDTH chunk per enabled clock,
// LSB chunk first.
//
// Optional build macro: CHECKSUM_EN adds oChecksum, the running XOR of all
// plaintext chunks written in the current run.
//
// Ports:
//   clk                      system clock, rising edge
//   rst                      asynchronous active-high reset
//   ena                      block enable; low freezes all state
//   iCiphertext              ciphertext, chunk k = bits [8k+7:8k]
//   iKey                     XOR key
//   iCiphertext_bit_counter  ciphertext shift-in count, full at MSG_WIDTH
//   iKey_bit_counter         key shift-in count, full at KEY_WIDTH
//   decryption_status        high while decrypting (and in the DONE cycle)
//   oDone                    one-cycle pulse after the last chunk is written
//   oPlaintext_counter       chunks completed, 0..NUM_CHUNKS
//   oPlaintext               recovered plaintext
//   oChecksum                (CHECKSUM_EN only) XOR of written chunks
module xor_decrypt #(
    parameter int MSG_WIDTH = 64,
    parameter int KEY_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ena,
    input  logic [MSG_WIDTH-1:0]                   iCiphertext,
    input  logic [KEY_WIDTH-1:0]                   iKey,
    input  logic [$clog2(MSG_WIDTH):0]             iCiphertext_bit_counter,
    input  logic [$clog2(KEY_WIDTH):0]             iKey_bit_counter,
    output logic                                   decryption_status,
    output logic                                   oDone,
    output logic [$clog2(MSG_WIDTH/KEY_WIDTH):0]   oPlaintext_counter,
    output logic [MSG_WIDTH-1:0]                   oPlaintext
`ifdef CHECKSUM_EN
    ,
    output logic [KEY_WIDTH-1:0]                   oChecksum
`endif
);

    localparam int NUM_CHUNKS = MSG_WIDTH / KEY_WIDTH;
    localparam int CW = $clog2(MSG_WIDTH) + 1;
    localparam int KW = $clog2(KEY_WIDTH) + 1;
    localparam int PW = $clog2(NUM_CHUNKS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [MSG_WIDTH-1:0]   snap_ct_q, snap_ct_d;
    logic [KEY_WIDTH-1:0]   snap_key_q, snap_key_d;
    logic [MSG_WIDTH-1:0]   pt_d;
    logic [PW-1:0]          cnt_d;
    logic                   done_d;
    logic                   status_d;
    logic [KEY_WIDTH-1:0]   chunk;
    logic                   full;
`ifdef CHECKSUM_EN
    logic [KEY_WIDTH-1:0]   chk_d;
`endif

    // Values above full (e.g. 65..127) are deliberately not treated as full.
    assign full = (iCiphertext_bit_counter == CW'(MSG_WIDTH)) &&
                  (iKey_bit_counter == KW'(KEY_WIDTH));

    always_comb begin
        state_d    = state_q;
        snap_ct_d  = snap_ct_q;
        snap_key_d = snap_key_q;
        pt_d       = oPlaintext;
        cnt_d      = oPlaintext_counter;
        done_d     = oDone;
        status_d   = decryption_status;
        chunk      = '0;
`ifdef CHECKSUM_EN
        chk_d      = oChecksum;
`endif
        case (state_q)
            IDLE: begin
                if (full) begin
                    snap_ct_d  = iCiphertext;
                    snap_key_d = iKey;
                    pt_d       = '0;
                    cnt_d      = '0;
                    status_d   = 1'b1;
`ifdef CHECKSUM_EN
                    chk_d      = '0;
`endif
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Constant-index select per chunk keeps the write decoder simple.
                for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
                    if (32'(oPlaintext_counter) == k) begin
                        chunk = snap_ct_q[k*KEY_WIDTH +: KEY_WIDTH] ^ snap_key_q;
                        pt_d[k*KEY_WIDTH +: KEY_WIDTH] = chunk;
                    end
                end
`ifdef CHECKSUM_EN
                chk_d = oChecksum ^ chunk;
`endif
                cnt_d = oPlaintext_counter + PW'(1);
                if (oPlaintext_counter == PW'(NUM_CHUNKS - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b0;
                status_d = 1'b0;
                state_d  = HOLD;
            end
            HOLD: begin
                // Require the counters to drop before another run may start.
                if (!full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            snap_ct_q          <= '0;
            snap_key_q         <= '0;
            oPlaintext         <= '0;
            oPlaintext_counter <= '0;
            oDone              <= 1'b0;
            decryption_status  <= 1'b0;
`ifdef CHECKSUM_EN
            oChecksum          <= '0;
`endif
        end else if (ena) begin
            state_q            <= state_d;
            snap_ct_q          <= snap_ct_d;
            snap_key_q         <= snap_key_d;
            oPlaintext         <= pt_d;
            oPlaintext_counter <= cnt_d;
            oDone              <= done_d;
            decryption_status  <= status_d;
`ifdef CHECKSUM_EN
            oChecksum          <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_xor_decrypt.sv
// tb_xor_decrypt: self-checking bench for xor_decrypt (64-bit message,
// 8-bit key). Expected values come from a reference model that computes the
// plaintext as ciphertext XOR replicated key, masked to the chunks completed.
module tb_xor_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [63:0] ct;
    logic [7:0]  key;
    logic [6:0]  ctc;
    logic [3:0]  kc;
    logic        status;
    logic        done;
    logic [3:0]  cnt;
    logic [63:0] pt;
`ifdef CHECKSUM_EN
    logic [7:0]  chk;
`endif

    int errors = 0;
    int checks = 0;

    xor_decrypt #(.MSG_WIDTH(64), .KEY_WIDTH(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ena                     (ena),
        .iCiphertext             (ct),
        .iKey                    (key),
        .iCiphertext_bit_counter (ctc),
        .iKey_bit_counter        (kc),
        .decryption_status       (status),
        .oDone                   (done),
        .oPlaintext_counter      (cnt),
        .oPlaintext              (pt)
`ifdef CHECKSUM_EN
        ,
        .oChecksum               (chk)
`endif
    );

    always #5 clk = ~clk;

    // Plaintext after n chunks: full XOR with the key replicated, low n bytes kept.
    function automatic logic [63:0] model_pt(input logic [63:0] c, input logic [7:0] k,
                                             input int n);
        logic [63:0] mask;
        mask = (n >= 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        return (c ^ {8{k}}) & mask;
    endfunction

    function automatic logic [7:0] model_chk(input logic [63:0] c, input logic [7:0] k,
                                            input int n);
        logic [63:0] p;
        logic [7:0]  x;
        p = model_pt(c, k, n);
        x = '0;
        for (int b = 0; b < 8; b++) x = x ^ p[b*8 +: 8];
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int n, input logic dexp,
                               input logic sexp, input logic [63:0] c, input logic [7:0] k);
        check({tag, "/cnt"},    64'(cnt),    64'(n));
        check({tag, "/pt"},     pt,          model_pt(c, k, n));
        check({tag, "/done"},   64'(done),   64'(dexp));
        check({tag, "/status"}, 64'(status), 64'(sexp));
`ifdef CHECKSUM_EN
        check({tag, "/chk"},    64'(chk),    64'(model_chk(c, k, n)));
`endif
    endtask

    // One complete run from the start edge to the HOLD state.
    task automatic run(input logic [63:0] c, input logic [7:0] k, input int stall_at,
                       input bit perturb, input string tag);
        ct = c; key = k; ctc = 7'd64; kc = 4'd8; ena = 1'b1;
        step();
        check_state({tag, "/start"}, 0, 1'b0, 1'b1, c, k);
        for (int i = 1; i <= 8; i++) begin
            step();
            check_state({tag, "/run"}, i, (i == 8), 1'b1, c, k);
            if (perturb && i >= 3) begin
                ct  = {$urandom, $urandom};
                key = 8'($urandom);
                ctc = 7'($urandom_range(0, 127));
                kc  = 4'($urandom_range(0, 15));
            end
            if (i == stall_at) begin
                ena = 1'b0;
                repeat (5) begin
                    step();
                    check_state({tag, "/stall"}, i, (i == 8), 1'b1, c, k);
                end
                ena = 1'b1;
            end
        end
        step();
        check_state({tag, "/end"}, 8, 1'b0, 1'b0, c, k);
    endtask

    task automatic release_counters(input logic [63:0] c, input logic [7:0] k, input string tag);
        ctc = '0; kc = '0; ena = 1'b1;
        step();
        check_state({tag, "/rel"}, 8, 1'b0, 1'b0, c, k);
    endtask

    initial begin
        logic [63:0] rc;
        logic [7:0]  rk;

        rst = 1'b1; ena = 1'b0; ct = '0; key = '0; ctc = '0; kc = '0;
        #1;
        check_state("reset", 0, 1'b0, 1'b0, '0, '0);
        step();
        rst = 1'b0;

        // Gating: not-full and over-full counters never start a run.
        ena = 1'b1; ct = 64'h0123456789ABCDEF; key = 8'h5A; ctc = 7'd64; kc = 4'd7;
        repeat (3) begin
            step();
            check_state("gate_k7", 0, 1'b0, 1'b0, '0, '0);
        end
        ctc = 7'd65; kc = 4'd8;
        step();
        check_state("gate_c65", 0, 1'b0, 1'b0, '0, '0);
        ctc = 7'd127;
        step();
        check_state("gate_c127", 0, 1'b0, 1'b0, '0, '0);
        ctc = 7'd64; kc = 4'd9;
        step();
        check_state("gate_k9", 0, 1'b0, 1'b0, '0, '0);
        ena = 1'b0; kc = 4'd8;
        step();
        check_state("gate_ena0", 0, 1'b0, 1'b0, '0, '0);

        // Basic decrypt.
        run(64'h0123456789ABCDEF, 8'h5A, 0, 1'b0, "basic");
        check("basic/value", pt, 64'h5B791F3DD3F197B5);
`ifdef CHECKSUM_EN
        check("basic/chkval", 64'(chk), 64'h00);
`endif

        // Counters held full after completion: no re-trigger.
        ctc = 7'd64; kc = 4'd8;
        repeat (3) begin
            step();
            check_state("hold", 8, 1'b0, 1'b0, 64'h0123456789ABCDEF, 8'h5A);
        end
        kc = 4'd0;
        step();
        check_state("hold_drop", 8, 1'b0, 1'b0, 64'h0123456789ABCDEF, 8'h5A);

        // Inputs scrambled mid-run and stalled: snapshot result unaffected.
        run(64'h0123456789ABCDEF, 8'h5A, 2, 1'b1, "stall_perturb");
        check("stall/value", pt, 64'h5B791F3DD3F197B5);
        release_counters(64'h0123456789ABCDEF, 8'h5A, "stall_perturb");

        // Reset in the middle of a run.
        ct = 64'h0123456789ABCDEF; key = 8'h5A; ctc = 7'd64; kc = 4'd8; ena = 1'b1;
        repeat (5) step();
        check_state("pre_rst", 4, 1'b0, 1'b1, ct, key);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 0, 1'b0, 1'b0, '0, '0);
        step();
        check_state("rst_held", 0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        run(64'h0123456789ABCDEF, 8'h5A, 0, 1'b0, "after_rst");
        release_counters(64'h0123456789ABCDEF, 8'h5A, "after_rst");

        // Checksum pattern.
        run(64'h00000000000000A5, 8'h00, 0, 1'b0, "chk");
        check("chk/value", pt, 64'h00000000000000A5);
`ifdef CHECKSUM_EN
        check("chk/chkval", 64'(chk), 64'hA5);
`endif
        release_counters(64'h00000000000000A5, 8'h00, "chk");

        // Randomized runs, including a stall while oDone is pending.
        for (int r = 0; r < 6; r++) begin
            rc = {$urandom, $urandom};
            rk = 8'($urandom);
            run(rc, rk, (r == 0) ? 8 : int'($urandom_range(0, 8)), 1'($urandom), "rand");
            release_counters(rc, rk, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
